// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port front end: formats load data, buffers loads in a small FIFO,
// and arbitrates one registered write per cycle with ALU results taking priority.
module regfile_wb_arbiter #(
    parameter int LDQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_rd,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] ld_rdata,
    output logic [4:0]  rd,
    output logic        we,
    output logic [31:0] wdata,
    output logic        ld_pending
);
    localparam int PW = (LDQ_DEPTH > 1) ? $clog2(LDQ_DEPTH) : 1;
    localparam int CW = $clog2(LDQ_DEPTH + 1);

    logic [PW-1:0] r_head, r_tail;
    logic [CW-1:0] r_count;
    logic [4:0]    r_q_rd   [LDQ_DEPTH];
    logic [31:0]   r_q_data [LDQ_DEPTH];
    logic [4:0]    r_rd;
    logic          r_we;
    logic [31:0]   r_wdata;

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_fmt;
    logic        w_push, w_pop, w_alu_issue;

    always_comb begin
        w_byte = ld_rdata[7:0];
        case (ld_offset)
            2'd1:    w_byte = ld_rdata[15:8];
            2'd2:    w_byte = ld_rdata[23:16];
            2'd3:    w_byte = ld_rdata[31:24];
            default: w_byte = ld_rdata[7:0];
        endcase
        w_half = ld_offset[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    end

    // Unsupported funct3 encodings fall through to a full-word load.
    always_comb begin
        w_fmt = ld_rdata;
        case (ld_funct3)
            3'd0:    w_fmt = {{24{w_byte[7]}}, w_byte};
            3'd4:    w_fmt = {24'd0, w_byte};
            3'd1:    w_fmt = {{16{w_half[15]}}, w_half};
            3'd5:    w_fmt = {16'd0, w_half};
            default: w_fmt = ld_rdata;
        endcase
    end

    assign ld_ready    = rst_n && (r_count < CW'(LDQ_DEPTH));
    assign ld_pending  = (r_count != '0);
    assign w_alu_issue = alu_valid && (alu_rd != 5'd0);
    assign w_push      = ld_valid && ld_ready && (ld_rd != 5'd0);
    assign w_pop       = !w_alu_issue && (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_rd[r_tail]   <= ld_rd;
            r_q_data[r_tail] <= w_fmt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + PW'(1);
            if (w_pop)  r_head <= r_head + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // rd/wdata hold their last value on idle cycles; only we drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_rd    <= 5'd0;
            r_wdata <= 32'd0;
        end else if (w_alu_issue) begin
            r_we    <= 1'b1;
            r_rd    <= alu_rd;
            r_wdata <= alu_data;
        end else if (w_pop) begin
            r_we    <= 1'b1;
            r_rd    <= r_q_rd[r_head];
            r_wdata <= r_q_data[r_head];
        end else begin
            r_we    <= 1'b0;
        end
    end

    assign rd    = r_rd;
    assign we    = r_we;
    assign wdata = r_wdata;
endmodule
